// File: rtl/wbm_spi_rx.sv
// SPI mode-0 slave receive path: pin synchronizers, MSB-first deserializer, valid/ready byte output.
// Optional sticky overrun flag enabled by defining WBM_SPI_RX_OVERRUN_EN.
module wbm_spi_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_csn,
  input  logic       spi_sdi,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic       overrun_clr
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sck_hist;
  logic [2:0]             r_cnt;
  logic [7:0]             r_shift;
  logic                   r_first_pend;
  logic [7:0]             r_data;
  logic                   r_first;
  logic                   r_valid;

  logic       w_sck;
  logic       w_csn;
  logic       w_sdi;
  logic       w_rise;
  logic       w_done;
  logic       w_take;
  logic [7:0] w_shift_nxt;

  assign w_sck       = r_sck_sync[SYNC_STAGES-1];
  assign w_csn       = r_csn_sync[SYNC_STAGES-1];
  assign w_sdi       = r_sdi_sync[SYNC_STAGES-1];
  assign w_rise      = w_sck & ~r_sck_hist & ~w_csn;
  assign w_shift_nxt = {r_shift[6:0], w_sdi};
  assign w_done      = w_rise & (r_cnt == 3'd7);
  assign w_take      = w_done & (~r_valid | rx_ready);

  // Reset values mirror the idle pins so no false sck edge appears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync <= '0;
      r_csn_sync <= '1;
      r_sdi_sync <= '0;
      r_sck_hist <= 1'b0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_csn_sync <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      r_sck_hist <= w_sck;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= 3'd0;
      r_shift      <= 8'd0;
      r_first_pend <= 1'b1;
      r_data       <= 8'd0;
      r_first      <= 1'b0;
      r_valid      <= 1'b0;
    end else begin
      if (w_csn) begin
        r_cnt        <= 3'd0;
        r_shift      <= 8'd0;
        r_first_pend <= 1'b1;
      end else if (w_rise) begin
        r_shift <= w_shift_nxt;
        r_cnt   <= r_cnt + 3'd1;
      end
      // A completing byte may replace the held one in the cycle it is consumed
      if (w_take) begin
        r_data       <= w_shift_nxt;
        r_valid      <= 1'b1;
        r_first      <= r_first_pend;
        r_first_pend <= 1'b0;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef WBM_SPI_RX_OVERRUN_EN
  logic r_ovr;
  logic w_drop;

  assign w_drop = w_done & r_valid & ~rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (overrun_clr) begin
      r_ovr <= 1'b0;
    end
  end

  assign rx_overrun = r_ovr;
`else
  logic w_unused;

  assign w_unused   = overrun_clr;
  assign rx_overrun = 1'b0;
`endif

  assign rx_data  = r_data;
  assign rx_first = r_first;
  assign rx_valid = r_valid;

endmodule

// File: tb/tb_wbm_spi_rx.sv
// Directed + randomized bench for wbm_spi_rx against a byte-level behavioural model.
// Expects rx_overrun activity only when WBM_SPI_RX_OVERRUN_EN is defined.
module tb_wbm_spi_rx;

  localparam int SS = 2;
`ifdef WBM_SPI_RX_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_csn = 1'b1;
  logic       spi_sdi = 1'b0;
  logic       rx_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_first;
  logic       rx_valid;
  logic       rx_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_data;
  bit         m_first, m_valid, m_ovr, m_fp;

  bit         mon_en = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  wbm_spi_rx #(.SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_csn    (spi_csn),
    .spi_sdi    (spi_sdi),
    .rx_data    (rx_data),
    .rx_first   (rx_first),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon_en && rx_valid && rx_ready)
      got_q.push_back({rx_first, rx_data});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit_rise(input logic b);
    spi_sck = 1'b0;
    spi_sdi = b;
    tick(4);
    spi_sck = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit_rise(b[7-i]);
      tick(4);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  // Last bit's rise, then strobe ready or clr exactly at the completing edge
  task automatic send_byte_pulse(input logic [7:0] b, input bit clr);
    send_bits(b, 7);
    send_bit_rise(b[0]);
    repeat (SS) @(posedge clk);
    #1;
    if (clr) overrun_clr = 1'b1;
    else rx_ready = 1'b1;
    @(posedge clk);
    #1;
    overrun_clr = 1'b0;
    rx_ready = 1'b0;
    tick(3);
  endtask

  task automatic frame_start();
    spi_sck = 1'b0;
    spi_csn = 1'b0;
    tick(2);
  endtask

  task automatic frame_end();
    tick(2);
    spi_csn = 1'b1;
    tick(2);
    spi_sck = 1'b0;
    tick(4);
    m_fp = 1'b1;
  endtask

  task automatic m_reset();
    m_data = 8'd0; m_first = 0; m_valid = 0; m_ovr = 0; m_fp = 1;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit rdy);
    if (!m_valid || rdy) begin
      m_data = b; m_first = m_fp; m_fp = 0; m_valid = 1;
    end else if (OVR) begin
      m_ovr = 1;
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    m_valid = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
    chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, "_first"}, 32'(rx_first), 32'(m_first));
    chk({tag, "_ovr"}, 32'(rx_overrun), 32'(m_ovr));
  endtask

  initial begin
    logic [7:0] b2b[6];
    logic [7:0] b;

    // Reset state
    m_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    check_all("reset");

    // Single byte with exact latency
    frame_start();
    send_bits(8'hA5, 7);
    send_bit_rise(1'b1);
    repeat (SS) @(posedge clk);
    @(negedge clk);
    chk("lat_pre", 32'(rx_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_post", 32'(rx_valid), 32'd1);
    tick(3);
    m_byte(8'hA5, 0);
    check_all("single");
    pulse_ready();
    check_all("consume");
    frame_end();

    // Back-to-back frame with ready held high
    b2b[0] = 8'h3C; b2b[1] = 8'hFF; b2b[2] = 8'h00;
    for (int i = 3; i < 6; i++) b2b[i] = 8'($urandom);
    rx_ready = 1'b1;
    mon_en = 1'b1;
    frame_start();
    for (int i = 0; i < 6; i++) begin
      send_byte(b2b[i]);
      m_byte(b2b[i], 1);
      exp_q.push_back({m_first, m_data});
      m_valid = 0;
    end
    frame_end();
    tick(4);
    mon_en = 1'b0;
    rx_ready = 1'b0;
    chk("b2b_count", 32'(got_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      chk($sformatf("b2b_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_all("b2b_end");

    // Overrun, clear-vs-set priority, same-cycle handoff
    frame_start();
    send_byte(8'h11);
    m_byte(8'h11, 0);
    send_byte(8'h22);
    m_byte(8'h22, 0);
    check_all("ovr");
    b = 8'($urandom);
    send_byte_pulse(b, 1'b1);
    m_byte(b, 0);
    check_all("ovr_setwins");
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    m_ovr = 0;
    check_all("ovr_clr");
    b = 8'($urandom);
    send_byte_pulse(b, 1'b0);
    m_byte(b, 1);
    check_all("handoff");
    pulse_ready();
    frame_end();

    // Aborted partial byte is discarded silently
    frame_start();
    send_bits(8'hF0, 5);
    spi_csn = 1'b1;
    tick(6);
    m_fp = 1;
    check_all("abort");
    frame_start();
    send_byte(8'h81);
    m_byte(8'h81, 0);
    check_all("abort_next");
    pulse_ready();
    tick(4);
    check_all("abort_one");
    frame_end();

    // Random bytes with random consumption between them
    frame_start();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send_byte(b);
      m_byte(b, 0);
      check_all($sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) pulse_ready();
    end
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    m_ovr = 0;
    pulse_ready();
    frame_end();
    check_all("rnd_end");

    // Reset mid-byte while a byte is held
    frame_start();
    b = 8'($urandom);
    send_byte(b);
    m_byte(b, 0);
    send_bits(8'($urandom), 4);
    spi_sck = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    m_reset();
    check_all("midrst");
    tick(SS + 2);
    send_byte(8'h5A);
    m_byte(8'h5A, 0);
    check_all("post_rst");
    pulse_ready();
    frame_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wbm_spi_rx.md
# wbm_spi_rx

SPI slave receive path for the Wishbone-bridged SPI peripheral; the counterpart of the SPI slave transmit path. It oversamples the asynchronous `spi_sck`, `spi_csn` and `spi_sdi` pins in the system clock domain and deserializes MSB-first bytes on SPI mode 0 rising edges. It then hands each byte to the Wishbone-side logic over a valid/ready interface. Frame-start marking and overrun detection are included.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each pin synchronizer; legal values are 2 or more.
- `clk`  in  1  system/Wishbone clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sck`  in  1  SPI clock from the controller; asynchronous to `clk`.
- `spi_csn`  in  1  active-low chip select; asynchronous.
- `spi_sdi`  in  1  serial data from the controller (MOSI); asynchronous.
- `rx_data`  out  8  received byte; held stable while `rx_valid` is high.
- `rx_first`  out  1  qualifies `rx_data`: this is the first byte after `spi_csn` fell.
- `rx_valid`  out  1  a byte is available.
- `rx_ready`  in  1  the consumer accepts the byte on `rx_valid & rx_ready`.
- `rx_overrun`  out  1  sticky flag: a completed byte was dropped.
- `overrun_clr`  in  1  single-cycle pulse that clears `rx_overrun`.

## Operation
- **Synchronizers**
  - Each pin passes through a `SYNC_STAGES` flip-flop chain, plus one history flop on sck.
  - Reset values match the idle pin state: sck 0, csn 1, sdi 0. This prevents a spurious edge after reset.
- **Chip select**
  - While synchronized csn is 1: bit counter = 0, partial shift register cleared, `first_pending` = 1.
  - csn rising mid-byte discards the partial byte silently. It is not an overrun.
- **Bit capture**
  - A sck rise is detected when synchronized sck = 1, history = 0 and synchronized csn = 0.
  - On each detected rise: shift = {shift[6:0], sdi_sync}, and the 3-bit counter increments, wrapping 7→0.
- **Byte complete** (a detected rise while counter = 7); the completed byte is the combinational next value of shift:
  - If `rx_valid` = 0, or `rx_ready` = 1 in the same cycle:
    - load `rx_data` and set `rx_valid` = 1;
    - `rx_first` ← `first_pending`;
    - `first_pending` ← 0.
  - Otherwise: the new byte is dropped, `rx_data`/`rx_first` are kept, and the overrun event fires.
- **Consume**
  - `rx_valid & rx_ready` with no completion in the same cycle → `rx_valid` = 0.
  - `rx_data` is not cleared.
- **Overrun**
  - The overrun event sets `rx_overrun`.
  - `overrun_clr` clears it.
  - If both occur in the same cycle, set wins.
- **Reset** (any time, including mid-byte): `rx_data` = 0, `rx_first` = 0, `rx_valid` = 0, `rx_overrun` = 0, counter = 0, shift = 0, `first_pending` = 1.

## Timing
- **SPI mode 0.** sdi must be stable from before the sck rise until at least 1 clk period after it.
- **Clock ratio.** sck high and low phases must each last at least 3 clk periods; `clk` ≥ 6× sck.
- **csn setup/hold.** csn falls at least 3 clk periods before the first sck rise. csn rises at least 3 clk periods after the last sck rise.
- **Latency.** Counting the clk edge that first samples sck high into stage 0 as edge 1, `rx_valid` is high after edge `SYNC_STAGES`+1. The sdi chain has the same depth as the sck chain, so data and clock stay aligned.
- **Handshake.**
  - Outputs are registered.
  - `rx_valid` is never deasserted without `rx_ready`.
  - `rx_ready` may be held high continuously.
- **Throughput.** One byte per 8 sck periods with no bubbles when the consumer keeps `rx_ready` high.

## Configuration
- **`WBM_SPI_RX_OVERRUN_EN` defined:** `rx_overrun` and `overrun_clr` behave as described in Operation.
- **`WBM_SPI_RX_OVERRUN_EN` undefined:**
  - `rx_overrun` is tied to 0 and `overrun_clr` is ignored.
  - A byte that completes while `rx_valid` = 1 and `rx_ready` = 0 still does not disturb the held byte; it is dropped silently.
  - Ports are present in both builds.

## Test plan
- **Single byte.** Reset; csn low; send 0xA5 MSB first with `rx_ready` = 0 → `rx_valid` = 1 with `rx_data` = 0xA5 and `rx_first` = 1 at edge `SYNC_STAGES`+1 after the 8th sck rise. Pulse `rx_ready` → `rx_valid` = 0.
- **Back-to-back frame.** 0x3C, 0xFF, 0x00 in one csn frame, `rx_ready` = 1 → three accepted bytes in order, with `rx_first` = 1, 0, 0.
- **Overrun (macro defined).** Send 0x11 then 0x22 with `rx_ready` = 0 → `rx_data` stays 0x11 and `rx_overrun` = 1. Assert `overrun_clr` in the same cycle as a third completed byte → `rx_overrun` = 1. `overrun_clr` alone → 0. Macro undefined: `rx_overrun` stays 0.
- **Aborted byte.** Raise csn after 5 bits of 0xF0, then send a full 0x81 in a new frame → exactly one byte, 0x81, with `rx_first` = 1.
- **Same-cycle handoff.** Align `rx_ready` with the completing edge of the next byte while `rx_valid` = 1 → `rx_valid` stays 1, `rx_data` updates to the new byte, and there is no overrun.
- **Reset mid-operation.** Assert `rst` after 4 bits and while `rx_valid` = 1 → all outputs are 0. A following full 0x5A is received with `rx_first` = 1.
